wb_trace_collector: RTL and testbench

Captures architectural write events from the pipelined `mips` core and buffers them for an external log consumer. These events are GRF writes from the W stage and data-memory stores from the M stage. The collector sits beside the core in the simulation top, on the receiving end of the core's commit-trace interface. It drains events in program order through a valid/ready port, and counts events lost to overflow.

---
 rtl/wb_trace_collector.sv | 121 ++++++++++++
 tb/tb_wb_trace_collector.sv | 284 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/wb_trace_collector.sv
// Commit-trace collector: buffers GRF writes and DM stores from the mips core in a
// dual-push, single-pop FIFO. Define TRACE_ZERO_REG_EN to also capture writes to $0.
module wb_trace_collector #(
    parameter int unsigned DEPTH_LOG2 = 3
) (
    input  logic        clk,
    input  logic        reset,

    input  logic        grf_we,
    input  logic [31:0] grf_pc,
    input  logic [4:0]  grf_addr,
    input  logic [31:0] grf_wdata,

    input  logic        dm_we,
    input  logic [31:0] dm_pc,
    input  logic [31:0] dm_addr,
    input  logic [31:0] dm_wdata,

    output logic        out_valid,
    input  logic        out_ready,
    output logic        out_kind,
    output logic [31:0] out_pc,
    output logic [31:0] out_addr,
    output logic [31:0] out_data,

    output logic        full,
    output logic [15:0] drop_cnt
);

    localparam int unsigned Depth = 1 << DEPTH_LOG2;
    localparam int unsigned PtrW  = DEPTH_LOG2;
    localparam int unsigned CntW  = DEPTH_LOG2 + 1;

    typedef struct packed {
        logic        kind;
        logic [31:0] pc;
        logic [31:0] addr;
        logic [31:0] data;
    } entry_t;

    entry_t          mem_q [Depth];
    entry_t          grf_entry;
    entry_t          dm_entry;
    entry_t          head;

    logic [PtrW-1:0] wr_ptr_q, wr_ptr_d;
    logic [PtrW-1:0] rd_ptr_q, rd_ptr_d;
    logic [PtrW-1:0] dm_slot;
    logic [CntW-1:0] count_q, count_d;
    logic [CntW-1:0] free_slots;
    logic [15:0]     drop_cnt_q, drop_cnt_d;
    logic [16:0]     drop_sum;
    logic [1:0]      n_push, n_drop;
    logic            grf_valid, dm_valid;
    logic            push_grf, push_dm, pop;

`ifdef TRACE_ZERO_REG_EN
    assign grf_valid = grf_we;
`else
    assign grf_valid = grf_we && (grf_addr != 5'd0);
`endif
    assign dm_valid = dm_we;

    always_comb begin
        grf_entry = '{kind: 1'b0, pc: grf_pc, addr: {27'b0, grf_addr}, data: grf_wdata};
        dm_entry  = '{kind: 1'b1, pc: dm_pc, addr: dm_addr, data: dm_wdata};
    end

    // Room is judged on the pre-pop count; the older GRF event claims a slot first.
    always_comb begin
        free_slots = CntW'(Depth) - count_q;
        push_grf   = grf_valid && (free_slots != '0);
        push_dm    = dm_valid && (grf_valid ? (free_slots >= CntW'(2)) : (free_slots != '0));
        pop        = out_valid && out_ready;

        n_push = {1'b0, push_grf} + {1'b0, push_dm};
        n_drop = {1'b0, grf_valid & ~push_grf} + {1'b0, dm_valid & ~push_dm};

        dm_slot  = push_grf ? (wr_ptr_q + PtrW'(1)) : wr_ptr_q;
        wr_ptr_d = wr_ptr_q + PtrW'(n_push);
        rd_ptr_d = rd_ptr_q + PtrW'(pop);
        count_d  = count_q + CntW'(n_push) - CntW'(pop);

        drop_sum   = {1'b0, drop_cnt_q} + 17'(n_drop);
        drop_cnt_d = drop_sum[16] ? 16'hFFFF : drop_sum[15:0];
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            drop_cnt_q <= '0;
        end else begin
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            drop_cnt_q <= drop_cnt_d;
        end
    end

    // Storage is not reset; occupancy is tracked solely by the pointers and count.
    always_ff @(posedge clk) begin
        if (push_grf) begin
            mem_q[wr_ptr_q] <= grf_entry;
        end
        if (push_dm) begin
            mem_q[dm_slot] <= dm_entry;
        end
    end

    assign head      = mem_q[rd_ptr_q];
    assign out_valid = (count_q != '0);
    assign out_kind  = head.kind;
    assign out_pc    = head.pc;
    assign out_addr  = head.addr;
    assign out_data  = head.data;
    assign full      = (count_q == CntW'(Depth));
    assign drop_cnt  = drop_cnt_q;

endmodule

// File: tb/tb_wb_trace_collector.sv
// Self-checking bench for wb_trace_collector: directed vector table, corner-case sequences
// and randomized traffic against a queue-based reference model.
module tb_wb_trace_collector;

    localparam int DEPTH = 8;

    logic        clk = 1'b0;
    logic        reset;
    logic        grf_we;
    logic [31:0] grf_pc;
    logic [4:0]  grf_addr;
    logic [31:0] grf_wdata;
    logic        dm_we;
    logic [31:0] dm_pc;
    logic [31:0] dm_addr;
    logic [31:0] dm_wdata;
    logic        out_valid;
    logic        out_ready;
    logic        out_kind;
    logic [31:0] out_pc;
    logic [31:0] out_addr;
    logic [31:0] out_data;
    logic        full;
    logic [15:0] drop_cnt;

    wb_trace_collector #(.DEPTH_LOG2(3)) dut (
        .clk      (clk),
        .reset    (reset),
        .grf_we   (grf_we),
        .grf_pc   (grf_pc),
        .grf_addr (grf_addr),
        .grf_wdata(grf_wdata),
        .dm_we    (dm_we),
        .dm_pc    (dm_pc),
        .dm_addr  (dm_addr),
        .dm_wdata (dm_wdata),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .out_kind (out_kind),
        .out_pc   (out_pc),
        .out_addr (out_addr),
        .out_data (out_data),
        .full     (full),
        .drop_cnt (drop_cnt)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        kind;
        logic [31:0] pc;
        logic [31:0] addr;
        logic [31:0] data;
    } ent_t;

    typedef struct {
        logic        gwe;
        logic [4:0]  gaddr;
        logic [31:0] gpc;
        logic [31:0] gdata;
        logic        dwe;
        logic [31:0] dpc;
        logic [31:0] daddr;
        logic [31:0] ddata;
        logic        rdy;
        logic        ev;
        logic        ek;
        logic [31:0] epc;
        logic [31:0] eaddr;
        logic [31:0] edata;
        logic        ef;
        logic [15:0] ed;
    } vec_t;

    ent_t        q[$];
    int unsigned mdrop;
    int          checks = 0;
    int          errors = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic set_in(input logic gwe, input logic [4:0] gaddr, input logic [31:0] gpc,
                          input logic [31:0] gdata, input logic dwe, input logic [31:0] dpc,
                          input logic [31:0] daddr, input logic [31:0] ddata, input logic rdy);
        grf_we = gwe; grf_addr = gaddr; grf_pc = gpc; grf_wdata = gdata;
        dm_we = dwe; dm_pc = dpc; dm_addr = daddr; dm_wdata = ddata;
        out_ready = rdy;
    endtask

    task automatic idle(input logic rdy);
        set_in(1'b0, 5'd0, 32'h0, 32'h0, 1'b0, 32'h0, 32'h0, 32'h0, rdy);
    endtask

    // Reference: pop the old head, then admit events oldest-first while pre-pop room lasts.
    task automatic model_step();
        int   room;
        bit   gv;
        ent_t e;
        room = DEPTH - q.size();
`ifdef TRACE_ZERO_REG_EN
        gv = grf_we;
`else
        gv = grf_we && (grf_addr != 5'd0);
`endif
        if (q.size() != 0 && out_ready) void'(q.pop_front());
        if (gv) begin
            if (room > 0) begin
                e = '{kind: 1'b0, pc: grf_pc, addr: {27'b0, grf_addr}, data: grf_wdata};
                q.push_back(e);
                room--;
            end else mdrop++;
        end
        if (dm_we) begin
            if (room > 0) begin
                e = '{kind: 1'b1, pc: dm_pc, addr: dm_addr, data: dm_wdata};
                q.push_back(e);
                room--;
            end else mdrop++;
        end
        if (mdrop > 65535) mdrop = 65535;
    endtask

    task automatic tick();
        @(posedge clk);
        model_step();
        #1;
    endtask

    task automatic check_model(input string tag);
        chk({tag, "_valid"}, {31'b0, out_valid}, {31'b0, q.size() != 0});
        chk({tag, "_full"}, {31'b0, full}, {31'b0, q.size() == DEPTH});
        chk({tag, "_drop"}, {16'b0, drop_cnt}, mdrop);
        if (q.size() != 0) begin
            chk({tag, "_kind"}, {31'b0, out_kind}, {31'b0, q[0].kind});
            chk({tag, "_pc"}, out_pc, q[0].pc);
            chk({tag, "_addr"}, out_addr, q[0].addr);
            chk({tag, "_data"}, out_data, q[0].data);
        end
    endtask

    vec_t vecs[8];

    initial begin
        vecs[0] = '{1'b1, 5'd5, 32'h3000, 32'h1234, 1'b0, 32'h0, 32'h0, 32'h0, 1'b0,
                    1'b1, 1'b0, 32'h3000, 32'h5, 32'h1234, 1'b0, 16'd0};
        vecs[1] = '{1'b0, 5'd0, 32'h0, 32'h0, 1'b0, 32'h0, 32'h0, 32'h0, 1'b0,
                    1'b1, 1'b0, 32'h3000, 32'h5, 32'h1234, 1'b0, 16'd0};
        vecs[2] = '{1'b0, 5'd0, 32'h0, 32'h0, 1'b0, 32'h0, 32'h0, 32'h0, 1'b1,
                    1'b0, 1'b0, 32'h0, 32'h0, 32'h0, 1'b0, 16'd0};
        vecs[3] = '{1'b1, 5'd8, 32'h3004, 32'h88, 1'b1, 32'h3008, 32'h10, 32'hABCD, 1'b0,
                    1'b1, 1'b0, 32'h3004, 32'h8, 32'h88, 1'b0, 16'd0};
        vecs[4] = '{1'b0, 5'd0, 32'h0, 32'h0, 1'b0, 32'h0, 32'h0, 32'h0, 1'b1,
                    1'b1, 1'b1, 32'h3008, 32'h10, 32'hABCD, 1'b0, 16'd0};
        vecs[5] = '{1'b0, 5'd0, 32'h0, 32'h0, 1'b0, 32'h0, 32'h0, 32'h0, 1'b1,
                    1'b0, 1'b0, 32'h0, 32'h0, 32'h0, 1'b0, 16'd0};
`ifdef TRACE_ZERO_REG_EN
        vecs[6] = '{1'b1, 5'd0, 32'h300C, 32'h77, 1'b0, 32'h0, 32'h0, 32'h0, 1'b0,
                    1'b1, 1'b0, 32'h300C, 32'h0, 32'h77, 1'b0, 16'd0};
`else
        vecs[6] = '{1'b1, 5'd0, 32'h300C, 32'h77, 1'b0, 32'h0, 32'h0, 32'h0, 1'b0,
                    1'b0, 1'b0, 32'h0, 32'h0, 32'h0, 1'b0, 16'd0};
`endif
        vecs[7] = '{1'b0, 5'd0, 32'h0, 32'h0, 1'b0, 32'h0, 32'h0, 32'h0, 1'b1,
                    1'b0, 1'b0, 32'h0, 32'h0, 32'h0, 1'b0, 16'd0};

        // Power-on reset
        reset = 1'b0;
        idle(1'b0);
        mdrop = 0;
        repeat (2) @(posedge clk);
        #1;
        chk("reset_valid", {31'b0, out_valid}, 32'd0);
        chk("reset_full", {31'b0, full}, 32'd0);
        chk("reset_drop", {16'b0, drop_cnt}, 32'd0);
        reset = 1'b1;

        // Directed vector table
        for (int i = 0; i < 8; i++) begin
            set_in(vecs[i].gwe, vecs[i].gaddr, vecs[i].gpc, vecs[i].gdata, vecs[i].dwe,
                   vecs[i].dpc, vecs[i].daddr, vecs[i].ddata, vecs[i].rdy);
            tick();
            chk($sformatf("vec%0d_valid", i), {31'b0, out_valid}, {31'b0, vecs[i].ev});
            chk($sformatf("vec%0d_full", i), {31'b0, full}, {31'b0, vecs[i].ef});
            chk($sformatf("vec%0d_drop", i), {16'b0, drop_cnt}, {16'b0, vecs[i].ed});
            if (vecs[i].ev) begin
                chk($sformatf("vec%0d_kind", i), {31'b0, out_kind}, {31'b0, vecs[i].ek});
                chk($sformatf("vec%0d_pc", i), out_pc, vecs[i].epc);
                chk($sformatf("vec%0d_addr", i), out_addr, vecs[i].eaddr);
                chk($sformatf("vec%0d_data", i), out_data, vecs[i].edata);
            end
        end

        // Overflow: 7 GRF events, then GRF+DM twice with the consumer stalled
        for (int i = 0; i < 7; i++) begin
            set_in(1'b1, 5'(i + 1), 32'h4000 + 32'(4 * i), 32'h100 + 32'(i), 1'b0, 32'h0,
                   32'h0, 32'h0, 1'b0);
            tick();
            check_model("ovf_fill");
        end
        chk("ovf_not_full_yet", {31'b0, full}, 32'd0);
        set_in(1'b1, 5'd20, 32'h401C, 32'h200, 1'b1, 32'h4020, 32'h40, 32'h300, 1'b0);
        tick();
        chk("ovf_full", {31'b0, full}, 32'd1);
        chk("ovf_drop1", {16'b0, drop_cnt}, 32'd1);
        check_model("ovf_first");
        set_in(1'b1, 5'd21, 32'h4024, 32'h201, 1'b1, 32'h4028, 32'h44, 32'h301, 1'b0);
        tick();
        chk("ovf_drop3", {16'b0, drop_cnt}, 32'd3);
        for (int i = 0; i < 9; i++) begin
            idle(1'b1);
            if (out_valid) chk("ovf_no_dm", {31'b0, out_kind}, 32'd0);
            tick();
            check_model("ovf_drain");
        end

        // Wrap-around with the consumer always ready
        for (int i = 0; i < 20; i++) begin
            set_in(1'b1, 5'(1 + i % 31), 32'h6000 + 32'(4 * i), $urandom, 1'b0, 32'h0, 32'h0,
                   32'h0, 1'b1);
            tick();
            check_model("wrap");
            chk("wrap_not_full", {31'b0, full}, 32'd0);
        end
        idle(1'b1);
        tick();
        check_model("wrap_end");

        // Reset pulse between edges with 5 entries in flight
        for (int i = 0; i < 5; i++) begin
            set_in(1'b1, 5'd3, 32'h7000 + 32'(4 * i), 32'(i), 1'b0, 32'h0, 32'h0, 32'h0, 1'b0);
            tick();
        end
        check_model("rst_pre");
        idle(1'b0);
        #2;
        reset = 1'b0;
        #1;
        chk("rst_valid", {31'b0, out_valid}, 32'd0);
        chk("rst_full", {31'b0, full}, 32'd0);
        chk("rst_drop", {16'b0, drop_cnt}, 32'd0);
        q.delete();
        mdrop = 0;
        #1;
        reset = 1'b1;
        set_in(1'b1, 5'd9, 32'h5000, 32'hCAFE, 1'b0, 32'h0, 32'h0, 32'h0, 1'b0);
        tick();
        chk("rst_first_pc", out_pc, 32'h5000);
        chk("rst_first_addr", out_addr, 32'h9);
        check_model("rst_post");
        idle(1'b1);
        tick();
        check_model("rst_drain");

        // Randomized traffic
        for (int i = 0; i < 400; i++) begin
            set_in(($urandom_range(0, 3) != 0), 5'($urandom_range(0, 31)), $urandom, $urandom,
                   ($urandom_range(0, 2) == 0), $urandom, {$urandom_range(0, 255), 2'b00},
                   $urandom, ($urandom_range(0, 3) < 2));
            tick();
            check_model("rand");
        end

        // Drop counter saturation: stalled and full, two drops per cycle
        for (int i = 0; i < 32800; i++) begin
            set_in(1'b1, 5'd7, 32'h8000, 32'(i), 1'b1, 32'h8004, 32'h80, 32'(i), 1'b0);
            tick();
            if (i % 1024 == 0) check_model("sat");
        end
        chk("sat_drop", {16'b0, drop_cnt}, 32'h0000FFFF);
        tick();
        chk("sat_hold", {16'b0, drop_cnt}, 32'h0000FFFF);
        check_model("sat_end");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
